// File: rtl/alu_pkg.sv
// Shared op-code constants and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // op[2] selects inverted B with carry-in 1 for the adder-based ops
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b101);
    endfunction

endpackage

// File: rtl/add_nb.sv
// WIDTH-bit combinational adder with carry-in and carry-out.
module add_nb #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] r,
    output logic             co
);

    assign {co, r} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add ops, WIDTH-cycle shift-add multiply,
// valid/ready handshakes on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               illegal_q, illegal_d;

    logic [WIDTH-1:0]   add_a, add_b, add_r;
    logic               add_ci, add_co, add_ovf;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   res_v;
    logic               accept;

    // The one adder is shared: partial sums while multiplying, operands otherwise
    always_comb begin
        if (state_q == ST_MUL) begin
            add_a  = acc_q[2*WIDTH-1:WIDTH];
            add_b  = mcand_q;
            add_ci = 1'b0;
        end else begin
            add_a  = a;
            add_b  = op[2] ? ~b : b;
            add_ci = op[2];
        end
    end

    add_nb #(.WIDTH(WIDTH)) u_add (
        .a  (add_a),
        .b  (add_b),
        .ci (add_ci),
        .r  (add_r),
        .co (add_co)
    );

    assign add_ovf  = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_r[WIDTH-1] != add_a[WIDTH-1]);
    assign accept   = in_valid && (state_q == ST_IDLE);
    // Low half holds the remaining multiplier bits, consumed LSB-first
    assign acc_step = acc_q[0] ? {add_co, add_r, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        res_v      = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    illegal_d  = op_is_illegal(op);
                    state_d    = ST_DONE;
                    case (op)
                        OP_AND: res_v = a & b;
                        OP_OR:  res_v = a | b;
                        OP_ADD, OP_SUB: begin
                            res_v      = add_r;
                            carry_d    = add_co;
                            overflow_d = add_ovf;
                        end
                        OP_SLT: begin
                            res_v   = {{(WIDTH-1){1'b0}}, add_r[WIDTH-1] ^ add_ovf};
                            carry_d = add_co;
                        end
                        OP_MUL: begin
                            mcand_d = a;
                            acc_d   = {{WIDTH{1'b0}}, b};
                            cnt_d   = '0;
                            state_d = ST_MUL;
                        end
                        default: res_v = '0;
                    endcase
                    if (op != OP_MUL) begin
                        result_d = res_v;
                        zero_d   = (res_v == '0);
                    end
                end
            end
            ST_MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = ST_DONE;
                    result_d   = acc_step[WIDTH-1:0];
                    zero_d     = (acc_step[WIDTH-1:0] == '0);
                    overflow_d = |acc_step[2*WIDTH-1:WIDTH];
                    carry_d    = 1'b0;
                    illegal_d  = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=16 with hand-computed expected results.
module tb_alu_mc;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, zero, carry, overflow, illegal;
    logic [W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one accepting edge, then scramble the inputs
    task automatic start(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        chk("pre_in_ready", 64'(in_ready), 64'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op = 3'b101; a = 16'hDEAD; b = 16'hBEEF;
    endtask

    task automatic wait_done(input string tag, input int lat0, input int exp_lat);
        int lat = lat0;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] r, input logic z,
                              input logic c, input logic o, input logic il);
        chk({tag, "_result"},   64'(result),   64'(r));
        chk({tag, "_zero"},     64'(zero),     64'(z));
        chk({tag, "_carry"},    64'(carry),    64'(c));
        chk({tag, "_overflow"}, 64'(overflow), 64'(o));
        chk({tag, "_illegal"},  64'(illegal),  64'(il));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_hs_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_hs_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int lat, input logic [W-1:0] r,
                         input logic z, input logic c, input logic ov, input logic il);
        start(o, x, y);
        wait_done(tag, 1, lat);
        expect_out(tag, r, z, c, ov, il);
        $display("[TB] %s op=%b a=%h b=%h -> result=%h z=%b c=%b v=%b ill=%b",
                 tag, o, x, y, result, zero, carry, overflow, illegal);
        handshake(tag);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        expect_out("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        do_op("add_ovf",  3'b010, 16'h7FFF, 16'h0001, 1, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("add_wrap", 3'b010, 16'hFFFF, 16'h0001, 1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("sub_eq",   3'b110, 16'h0005, 16'h0005, 1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op("slt_true", 3'b111, 16'hFFFF, 16'h0001, 1, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op("slt_false",3'b111, 16'h0001, 16'hFFFF, 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("and",      3'b000, 16'hF0F0, 16'h3C3C, 1, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("or",       3'b001, 16'hF0F0, 16'h3C3C, 1, 16'hFCFC, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("ill_100",  3'b100, 16'h1234, 16'h5678, 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op("ill_101",  3'b101, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op("mul_ovf",  3'b011, 16'h0100, 16'h0100, 17, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

        // MUL with a competing request presented while busy
        start(3'b011, 16'h00FF, 16'h0003);
        step(); step();
        op = 3'b010; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        chk("busy_in_ready", 64'(in_ready), 64'd0);
        step(); step(); step();
        in_valid = 1'b0;
        wait_done("mul_small", 6, 17);
        expect_out("mul_small", 16'h02FD, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] mul_small op=011 a=00ff b=0003 -> result=%h v=%b", result, overflow);
        handshake("mul_small");

        // Back-pressure: result must hold, and a waiting request must not slip in on the handshake edge
        start(3'b010, 16'h1234, 16'h1111);
        wait_done("bp", 1, 1);
        op = 3'b010; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_result", 64'(result), 64'h2345);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        $display("[TB] bp op=010 a=1234 b=1111 -> result=%h held 3 cycles", result);
        handshake("bp");
        step();
        in_valid = 1'b0;
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        expect_out("bp_next", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] bp_next op=010 a=0001 b=0001 -> result=%h", result);
        handshake("bp_next");

        // Reset in the middle of a multiply
        start(3'b011, 16'h0100, 16'h0100);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        expect_out("mrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        rst_n = 1'b1;
        chk("mrst_release_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("mrst_no_valid", 64'(out_valid), 64'd0);
        $display("[TB] mrst reset during MUL iteration 5 -> outputs cleared");
        do_op("post_rst_add", 3'b010, 16'h0002, 16'h0003, 1, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
